// File: rtl/instruction_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_fetch_sequencer
//
// Front end of the 8-bit mini CPU's instruction decoder. The sequencer
// fetches opcodes from a synchronous-read program memory and holds each one
// in an instruction register. It then presents the opcode to the decoder
// for exactly one execute cycle. It supports three modes: free-run (Run
// held high), single-step (Step pulse from IDLE) and a sticky halt when
// HALT_CODE is fetched.
//
// Each instruction takes three cycles: FETCH -> LATCH -> EXEC.
//   FETCH : ProgAddr <= PC
//   LATCH : IR <= ProgData (memory data for ProgAddr is valid this cycle)
//   EXEC  : Instruction/InstrValid show the opcode; PC <= PC + 1 at the end
//
// Ports
//   Clock        in   1        system clock, rising edge
//   Reset        in   1        synchronous, active-high reset
//   Run          in   1        level: fetch/execute continuously while high
//   Step         in   1        pulse: execute one instruction from IDLE
//   HaltReq      in   1        stop after the in-flight instruction
//   ProgAddr     out  ADDR_W   registered program memory address
//   ProgData     in   INSTR_W  program memory read data for ProgAddr
//   Instruction  out  INSTR_W  opcode to decoder, NOP_CODE unless InstrValid
//   InstrValid   out  1        one-cycle pulse per executed instruction
//   PC           out  ADDR_W   current program counter
//   Busy         out  1        high in FETCH, LATCH, EXEC
//   Halted       out  1        high in HALTED
// ---------------------------------------------------------------------------
module instruction_fetch_sequencer #(
    parameter int                 ADDR_W    = 4,
    parameter int                 INSTR_W   = 4,
    parameter logic [INSTR_W-1:0] NOP_CODE  = 4'b0000,
    parameter logic [INSTR_W-1:0] HALT_CODE = 4'b1111
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Step,
    input  logic               HaltReq,
    output logic [ADDR_W-1:0]  ProgAddr,
    input  logic [INSTR_W-1:0] ProgData,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic [ADDR_W-1:0]  PC,
    output logic               Busy,
    output logic               Halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t             state,      state_nxt;
    logic [ADDR_W-1:0]  pc,         pc_nxt;
    logic [ADDR_W-1:0]  prog_addr,  prog_addr_nxt;
    logic [INSTR_W-1:0] ir,         ir_nxt;
    logic [INSTR_W-1:0] instr,      instr_nxt;
    logic               instr_vld,  instr_vld_nxt;
    logic               step_mode,  step_mode_nxt;

    // NOTE: every state element is written with <= so all registers update
    // together from values computed before the edge; reset is synchronous,
    // so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            prog_addr <= '0;
            ir        <= NOP_CODE;
            instr     <= NOP_CODE;
            instr_vld <= 1'b0;
            step_mode <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            prog_addr <= prog_addr_nxt;
            ir        <= ir_nxt;
            instr     <= instr_nxt;
            instr_vld <= instr_vld_nxt;
            step_mode <= step_mode_nxt;
        end
    end

    // NOTE: every signal gets a default at the top, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        prog_addr_nxt = prog_addr;
        ir_nxt        = ir;
        step_mode_nxt = step_mode;
        // The output pair is a one-cycle pulse by default: it is only
        // loaded on the LATCH->EXEC edge, so it is stable for all of EXEC.
        instr_nxt     = NOP_CODE;
        instr_vld_nxt = 1'b0;

        unique case (state)
            S_IDLE: begin
                // HaltReq holds off a start; Run outranks Step and clears
                // any leftover single-step request.
                if (!HaltReq) begin
                    if (Run) begin
                        state_nxt     = S_FETCH;
                        step_mode_nxt = 1'b0;
                    end else if (Step) begin
                        state_nxt     = S_FETCH;
                        step_mode_nxt = 1'b1;
                    end
                end
            end

            S_FETCH: begin
                prog_addr_nxt = pc;
                state_nxt     = S_LATCH;
            end

            S_LATCH: begin
                ir_nxt = ProgData;
                if (ProgData == HALT_CODE) begin
                    // The halt opcode is never forwarded and PC stays on it.
                    state_nxt = S_HALTED;
                end else begin
                    instr_nxt     = ProgData;
                    instr_vld_nxt = 1'b1;
                    state_nxt     = S_EXEC;
                end
            end

            S_EXEC: begin
                // The increment wraps naturally at 2**ADDR_W.
                pc_nxt = pc + 1'b1;
                if (step_mode || HaltReq || !Run) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end

            S_HALTED: begin
                state_nxt = S_HALTED;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign ProgAddr    = prog_addr;
    assign PC          = pc;
    assign Instruction = instr;
    assign InstrValid  = instr_vld;
    assign Busy        = (state == S_FETCH) || (state == S_LATCH) || (state == S_EXEC);
    assign Halted      = (state == S_HALTED);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_sequencer
//
// Directed bench for instruction_fetch_sequencer. The program memory is a
// bench-owned array read through the DUT's registered ProgAddr. Each scenario
// task drives stimulus and compares the DUT outputs against hand-derived
// values. Inputs are driven and outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic       Step;
    logic       HaltReq;
    logic [3:0] ProgAddr;
    logic [3:0] ProgData;
    logic [3:0] Instruction;
    logic       InstrValid;
    logic [3:0] PC;
    logic       Busy;
    logic       Halted;

    logic [3:0] mem [16];

    int checks = 0;
    int errors = 0;

    instruction_fetch_sequencer #(
        .ADDR_W   (4),
        .INSTR_W  (4),
        .NOP_CODE (4'b0000),
        .HALT_CODE(4'b1111)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Run        (Run),
        .Step       (Step),
        .HaltReq    (HaltReq),
        .ProgAddr   (ProgAddr),
        .ProgData   (ProgData),
        .Instruction(Instruction),
        .InstrValid (InstrValid),
        .PC         (PC),
        .Busy       (Busy),
        .Halted     (Halted)
    );

    assign ProgData = mem[ProgAddr];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        Run     = 1'b0;
        Step    = 1'b0;
        HaltReq = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic fill_mem(input logic [3:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    // Advance until InstrValid is seen or the budget runs out.
    task automatic wait_valid(input int budget, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (InstrValid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({PC, ProgAddr, Instruction, InstrValid, Busy, Halted} !== 15'h0) begin
            errors++;
            $display("FAIL reset_state: PC=%h ProgAddr=%h Instr=%h V=%b B=%b H=%b, want all 0",
                     PC, ProgAddr, Instruction, InstrValid, Busy, Halted);
        end
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        int n;
        fill_mem(4'h2);
        do_reset();
        Run = 1'b1;
        for (int k = 0; k < 6; k++) wait_valid(5, seen, n);
        checks++;
        if (!(seen && PC === 4'd5 && InstrValid === 1'b1)) begin
            errors++;
            $display("FAIL mid_exec_setup: seen=%b PC=%h V=%b, want 1 5 1", seen, PC, InstrValid);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if ({PC, ProgAddr, Instruction, InstrValid, Busy, Halted} !== 15'h0) begin
            errors++;
            $display("FAIL reset_mid_exec: PC=%h ProgAddr=%h Instr=%h V=%b B=%b H=%b, want all 0",
                     PC, ProgAddr, Instruction, InstrValid, Busy, Halted);
        end
        Run   = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_free_run();
        bit         seen;
        int         n;
        logic [3:0] exp_op [3];
        exp_op[0] = 4'h3;
        exp_op[1] = 4'hD;
        exp_op[2] = 4'h7;
        fill_mem(4'h0);
        mem[0] = 4'h3;
        mem[1] = 4'hD;
        mem[2] = 4'h7;
        do_reset();
        Run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(6, seen, n);
            checks++;
            if (!(seen && n == 3)) begin
                errors++;
                $display("FAIL run_spacing[%0d]: seen=%b after %0d cycles, want 3", k, seen, n);
            end
            checks++;
            if (Instruction !== exp_op[k] || PC !== 4'(k)) begin
                errors++;
                $display("FAIL run_exec[%0d]: Instr=%h PC=%h, want %h %h", k, Instruction, PC, exp_op[k], 4'(k));
            end
        end
        Run = 1'b0;
        tick();
        checks++;
        if (PC !== 4'd3 || Busy !== 1'b0 || InstrValid !== 1'b0 || Instruction !== 4'h0) begin
            errors++;
            $display("FAIL run_stop: PC=%h B=%b V=%b Instr=%h, want 3 0 0 0", PC, Busy, InstrValid, Instruction);
        end
    endtask

    task automatic step_once();
        bit seen;
        int n;
        Step = 1'b1;
        tick();
        Step = 1'b0;
        wait_valid(5, seen, n);
        tick();
    endtask

    task automatic test_step();
        bit seen;
        int n;
        int extra;
        fill_mem(4'h1);
        mem[2] = 4'hA;
        do_reset();
        step_once();
        step_once();
        checks++;
        if (PC !== 4'd2 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL step_setup: PC=%h B=%b, want 2 0", PC, Busy);
        end
        Step = 1'b1;
        tick();
        Step = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL step_start: Busy=%b, want 1", Busy);
        end
        // Second Step while busy must be dropped, not queued.
        Step = 1'b1;
        tick();
        Step = 1'b0;
        wait_valid(4, seen, n);
        checks++;
        if (!seen || Instruction !== 4'hA) begin
            errors++;
            $display("FAIL step_exec: seen=%b Instr=%h, want 1 a", seen, Instruction);
        end
        extra = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (InstrValid === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || PC !== 4'd3 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL step_single: extra=%0d PC=%h B=%b, want 0 3 0", extra, PC, Busy);
        end
    endtask

    task automatic test_halt_code();
        int cnt;
        fill_mem(4'h5);
        mem[0] = 4'h1;
        mem[1] = 4'h2;
        mem[2] = 4'h3;
        mem[3] = 4'h4;
        mem[4] = 4'hF;
        do_reset();
        Run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (InstrValid === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 4 || Halted !== 1'b1 || PC !== 4'd4 || Busy !== 1'b0 || Instruction !== 4'h0) begin
            errors++;
            $display("FAIL halt_code: valids=%0d H=%b PC=%h B=%b Instr=%h, want 4 1 4 0 0",
                     cnt, Halted, PC, Busy, Instruction);
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            Step = i[0];
            tick();
            if (InstrValid === 1'b1 || Busy === 1'b1) cnt++;
        end
        Step = 1'b0;
        checks++;
        if (cnt != 0 || Halted !== 1'b1 || PC !== 4'd4) begin
            errors++;
            $display("FAIL halt_sticky: activity=%0d H=%b PC=%h, want 0 1 4", cnt, Halted, PC);
        end
        Run = 1'b0;
        do_reset();
        checks++;
        if (Halted !== 1'b0 || PC !== 4'd0) begin
            errors++;
            $display("FAIL halt_reset: H=%b PC=%h, want 0 0", Halted, PC);
        end
    endtask

    task automatic test_pc_wrap();
        bit seen;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        mem[0]  = 4'h6;
        mem[15] = 4'hC;
        do_reset();
        Run = 1'b1;
        for (int k = 0; k < 16; k++) wait_valid(5, seen, n);
        checks++;
        if (!seen || PC !== 4'hF || Instruction !== 4'hC) begin
            errors++;
            $display("FAIL wrap_last: seen=%b PC=%h Instr=%h, want 1 f c", seen, PC, Instruction);
        end
        wait_valid(5, seen, n);
        checks++;
        if (!seen || PC !== 4'h0 || ProgAddr !== 4'h0 || Instruction !== 4'h6) begin
            errors++;
            $display("FAIL wrap_first: seen=%b PC=%h ProgAddr=%h Instr=%h, want 1 0 0 6",
                     seen, PC, ProgAddr, Instruction);
        end
        Run = 1'b0;
        tick();
    endtask

    task automatic test_halt_req();
        fill_mem(4'h8);
        mem[0] = 4'h3;
        do_reset();
        Run = 1'b1;
        tick();            // FETCH
        tick();            // LATCH
        HaltReq = 1'b1;
        tick();            // EXEC
        checks++;
        if (InstrValid !== 1'b1 || Instruction !== 4'h3) begin
            errors++;
            $display("FAIL haltreq_exec: V=%b Instr=%h, want 1 3", InstrValid, Instruction);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || PC !== 4'd1 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL haltreq_idle: B=%b PC=%h V=%b, want 0 1 0", Busy, PC, InstrValid);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (Busy !== 1'b0 || PC !== 4'd1) begin
            errors++;
            $display("FAIL haltreq_block: B=%b PC=%h, want 0 1", Busy, PC);
        end
        HaltReq = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL haltreq_release: B=%b, want 1", Busy);
        end
        Run = 1'b0;
    endtask

    initial begin
        Reset   = 1'b1;
        Run     = 1'b0;
        Step    = 1'b0;
        HaltReq = 1'b0;
        fill_mem(4'h0);
        test_reset();
        test_reset_mid_exec();
        test_free_run();
        test_step();
        test_halt_code();
        test_pc_wrap();
        test_halt_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
